// File: rtl/sample_feeder.sv
// sample_feeder: training-sample buffer for the perceptron controller/datapath.
// Latency: sample 0 is on the buses the cycle after start; each readyToGetData advances the buses at that edge.
// Backpressure: none; writes to a full buffer are dropped, and writes/clears are ignored while feeding.
//
// Ports:
//   clk, rstN (synchronous, active-low)
//   clearMem, wrEn, wrX1, wrX2, wrT        : buffer load side (IDLE only)
//   start, readyToGetData, doneSignal      : controller handshake
//   x1Bus, x2Bus, tBus                     : registered current sample (tBus = +1/-1)
//   nBus, sampleCount, full, busy, startErr: status
//   epochCnt                               : only when SAMPLE_FEEDER_EPOCH_CNT_EN is defined
module sample_feeder #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 64,
   parameter int ADDR_W = 6
) (
   input  logic                     clk,
   input  logic                     rstN,
   input  logic                     clearMem,
   input  logic                     wrEn,
   input  logic signed [DATA_W-1:0] wrX1,
   input  logic signed [DATA_W-1:0] wrX2,
   input  logic                     wrT,
   input  logic                     start,
   input  logic                     readyToGetData,
   input  logic                     doneSignal,
   output logic signed [DATA_W-1:0] x1Bus,
   output logic signed [DATA_W-1:0] x2Bus,
   output logic signed [DATA_W-1:0] tBus,
   output logic [32:0]              nBus,
   output logic [ADDR_W:0]          sampleCount,
   output logic                     full,
   output logic                     busy,
   output logic                     startErr
`ifdef SAMPLE_FEEDER_EPOCH_CNT_EN
   ,
   output logic [15:0]              epochCnt
`endif
);

   typedef enum logic {IDLE, FEED} state_t;

   state_t state, nextState;

   // Entry layout: {x1, x2, t}
   logic [2*DATA_W:0] mem [DEPTH];
   logic [2*DATA_W:0] rdEntry;
   logic [ADDR_W-1:0] rdPtr;
   logic [ADDR_W-1:0] rdSel;
   logic [ADDR_W:0]   lastIdx;
   logic              ptrWrap;
   logic              accStart;
   logic              doClear;
   logic              doWrite;
   logic              doAdvance;
   logic              doDone;

   // A start that is accepted takes precedence over a same-cycle clearMem,
   // so the feeder never enters FEED with an empty buffer.
   assign accStart  = (state == IDLE) && start && (sampleCount != '0);
   assign doClear   = (state == IDLE) && clearMem && !accStart;
   assign doWrite   = (state == IDLE) && wrEn && !full && !clearMem;
   assign doDone    = (state == FEED) && doneSignal;
   assign doAdvance = (state == FEED) && readyToGetData && !doneSignal;

   assign lastIdx = sampleCount - (ADDR_W+1)'(1);
   assign ptrWrap = ({1'b0, rdPtr} == lastIdx);
   assign rdSel   = accStart ? '0 : rdPtr;
   assign rdEntry = mem[rdSel];

   assign full = (sampleCount == (ADDR_W+1)'(DEPTH));
   assign nBus = {{(32-ADDR_W){1'b0}}, sampleCount};

   // State register
   always_ff @(posedge clk) begin
      if (!rstN) state <= IDLE;
      else       state <= nextState;
   end

   // Next-state logic
   always_comb begin
      nextState = state;
      case (state)
         IDLE:    if (accStart) nextState = FEED;
         FEED:    if (doneSignal) nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   // Outputs decoded from state
   always_comb begin
      busy     = (state == FEED);
      startErr = rstN && (state == IDLE) && start && (sampleCount == '0);
   end

   // Sample storage; contents are meaningless beyond sampleCount, so no reset.
   always_ff @(posedge clk) begin
      if (doWrite) mem[sampleCount[ADDR_W-1:0]] <= {wrX1, wrX2, wrT};
   end

   // Count, read pointer and registered sample buses
   always_ff @(posedge clk) begin
      if (!rstN) begin
         sampleCount <= '0;
         rdPtr       <= '0;
         x1Bus       <= '0;
         x2Bus       <= '0;
         tBus        <= '0;
      end else begin
         if (doClear)      sampleCount <= '0;
         else if (doWrite) sampleCount <= sampleCount + (ADDR_W+1)'(1);

         if (accStart || doAdvance) begin
            x1Bus <= rdEntry[2*DATA_W:DATA_W+1];
            x2Bus <= rdEntry[DATA_W:1];
            // t=1 -> 0...01 (+1), t=0 -> 1...11 (-1)
            tBus  <= {{(DATA_W-1){~rdEntry[0]}}, 1'b1};
         end

         if (accStart)
            rdPtr <= (sampleCount == (ADDR_W+1)'(1)) ? '0 : ADDR_W'(1);
         else if (doDone || doClear)
            rdPtr <= '0;
         else if (doAdvance)
            rdPtr <= ptrWrap ? '0 : rdPtr + ADDR_W'(1);
      end
   end

`ifdef SAMPLE_FEEDER_EPOCH_CNT_EN
   // Counts completed passes over the buffer: one per rdPtr wrap while feeding.
   always_ff @(posedge clk) begin
      if (!rstN || accStart)
         epochCnt <= '0;
      else if (doAdvance && ptrWrap && (epochCnt != 16'hFFFF))
         epochCnt <= epochCnt + 16'd1;
   end
`endif

endmodule

// File: tb/tb_sample_feeder.sv
// tb_sample_feeder: scoreboard bench for sample_feeder.
// Expected samples are pushed when start/readyToGetData is driven, popped one cycle later.
// Inputs driven 1 time unit after the rising edge; outputs sampled there as well.
module tb_sample_feeder;

   localparam int DATA_W = 16;
   localparam int DEPTH  = 64;
   localparam int ADDR_W = 6;

   typedef struct packed {
      logic [15:0] x1;
      logic [15:0] x2;
      logic [15:0] t;
   } smp_t;

   logic        clk = 1'b0;
   logic        rstN;
   logic        clearMem;
   logic        wrEn;
   logic [15:0] wrX1;
   logic [15:0] wrX2;
   logic        wrT;
   logic        start;
   logic        readyToGetData;
   logic        doneSignal;
   logic [15:0] x1Bus;
   logic [15:0] x2Bus;
   logic [15:0] tBus;
   logic [32:0] nBus;
   logic [6:0]  sampleCount;
   logic        full;
   logic        busy;
   logic        startErr;
`ifdef SAMPLE_FEEDER_EPOCH_CNT_EN
   logic [15:0] epochCnt;
`endif

   int   nChecks = 0;
   int   nFails  = 0;
   smp_t sbQ[$];
   smp_t mdl[DEPTH];
   smp_t lastSmp;
   int   mdlCount = 0;
   int   mdlPtr   = 0;

   always #5 clk = ~clk;

   sample_feeder #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk            (clk),
      .rstN           (rstN),
      .clearMem       (clearMem),
      .wrEn           (wrEn),
      .wrX1           (wrX1),
      .wrX2           (wrX2),
      .wrT            (wrT),
      .start          (start),
      .readyToGetData (readyToGetData),
      .doneSignal     (doneSignal),
      .x1Bus          (x1Bus),
      .x2Bus          (x2Bus),
      .tBus           (tBus),
      .nBus           (nBus),
      .sampleCount    (sampleCount),
      .full           (full),
      .busy           (busy),
      .startErr       (startErr)
`ifdef SAMPLE_FEEDER_EPOCH_CNT_EN
      ,
      .epochCnt       (epochCnt)
`endif
   );

   task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nChecks++;
      if (got !== exp) begin
         nFails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic writeSample(input int a, input int b, input bit t);
      wrEn = 1'b1;
      wrX1 = a[15:0];
      wrX2 = b[15:0];
      wrT  = t;
      tick();
      wrEn = 1'b0;
      if (mdlCount < DEPTH) begin
         mdl[mdlCount] = '{x1: a[15:0], x2: b[15:0], t: (t ? 16'h0001 : 16'hFFFF)};
         mdlCount++;
      end
   endtask

   task automatic popCheck(input string tag);
      smp_t e;
      if (sbQ.size() == 0) begin
         checkVal({tag, "_sbEmpty"}, 64'd1, 64'd0);
      end else begin
         e = sbQ.pop_front();
         lastSmp = e;
         checkVal({tag, "_x1"}, 64'(x1Bus), 64'(e.x1));
         checkVal({tag, "_x2"}, 64'(x2Bus), 64'(e.x2));
         checkVal({tag, "_t"},  64'(tBus),  64'(e.t));
      end
   endtask

   task automatic startFeed(input string tag);
      start = 1'b1;
      sbQ.push_back(mdl[0]);
      mdlPtr = (mdlCount == 1) ? 0 : 1;
      tick();
      start = 1'b0;
      checkVal({tag, "_busy"}, 64'(busy), 64'd1);
      popCheck(tag);
   endtask

   task automatic requestNext(input string tag);
      readyToGetData = 1'b1;
      sbQ.push_back(mdl[mdlPtr]);
      mdlPtr = (mdlPtr == mdlCount - 1) ? 0 : mdlPtr + 1;
      tick();
      readyToGetData = 1'b0;
      popCheck(tag);
   endtask

   initial begin
      rstN = 1'b0; clearMem = 1'b0; wrEn = 1'b0; wrX1 = '0; wrX2 = '0; wrT = 1'b0;
      start = 1'b0; readyToGetData = 1'b0; doneSignal = 1'b0;
      tick();
      tick();
      checkVal("rst_count", 64'(sampleCount), 64'd0);
      checkVal("rst_busy",  64'(busy),        64'd0);
      checkVal("rst_full",  64'(full),        64'd0);
      checkVal("rst_err",   64'(startErr),    64'd0);
      checkVal("rst_x1",    64'(x1Bus),       64'd0);
      checkVal("rst_x2",    64'(x2Bus),       64'd0);
      checkVal("rst_t",     64'(tBus),        64'd0);
      rstN = 1'b1;

      // Three samples, then one full pass plus wrap
      writeSample(5, -3, 1'b1);
      writeSample(2, 7, 1'b0);
      writeSample(-1, -1, 1'b1);
      checkVal("w3_count", 64'(sampleCount), 64'd3);
      checkVal("w3_nBus",  64'(nBus),        64'd3);
      checkVal("w3_full",  64'(full),        64'd0);
      checkVal("w3_x1",    64'(x1Bus),       64'd0);
      checkVal("w3_t",     64'(tBus),        64'd0);

      startFeed("start3");
      requestNext("adv1");
      requestNext("adv2");
      requestNext("adv0wrap");
`ifdef SAMPLE_FEEDER_EPOCH_CNT_EN
      checkVal("epoch3", 64'(epochCnt), 64'd1);
`endif
      checkVal("feed_nBus", 64'(nBus), 64'd3);

      // doneSignal wins over readyToGetData; buses hold
      doneSignal = 1'b1;
      readyToGetData = 1'b1;
      tick();
      doneSignal = 1'b0;
      readyToGetData = 1'b0;
      mdlPtr = 0;
      checkVal("done_busy", 64'(busy), 64'd0);
      checkVal("done_x1", 64'(x1Bus), 64'(lastSmp.x1));
      checkVal("done_x2", 64'(x2Bus), 64'(lastSmp.x2));
      tick();
      checkVal("idle_busy", 64'(busy), 64'd0);

      startFeed("restart");
      requestNext("restart_adv1");

      // Writes while feeding are ignored
      wrEn = 1'b1; wrX1 = 16'd99; wrX2 = 16'd99; wrT = 1'b1;
      tick();
      wrEn = 1'b0;
      checkVal("feed_wr_count", 64'(sampleCount), 64'd3);

      // Reset mid-FEED
      rstN = 1'b0;
      tick();
      rstN = 1'b1;
      mdlCount = 0;
      checkVal("midrst_busy",  64'(busy),        64'd0);
      checkVal("midrst_count", 64'(sampleCount), 64'd0);
      checkVal("midrst_x1",    64'(x1Bus),       64'd0);
      checkVal("midrst_x2",    64'(x2Bus),       64'd0);
      checkVal("midrst_t",     64'(tBus),        64'd0);

      // Start with empty buffer
      start = 1'b1;
      #1;
      checkVal("empty_err_hi", 64'(startErr), 64'd1);
      tick();
      start = 1'b0;
      #1;
      checkVal("empty_err_lo", 64'(startErr), 64'd0);
      checkVal("empty_busy",   64'(busy),     64'd0);
      checkVal("empty_x1",     64'(x1Bus),    64'd0);
      tick();
      checkVal("empty_busy2",  64'(busy),     64'd0);

      // Fill to DEPTH, then one extra write
      for (int i = 0; i < DEPTH; i++)
         writeSample(int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)));
      checkVal("fill_full",  64'(full),        64'd1);
      checkVal("fill_count", 64'(sampleCount), 64'(DEPTH));
      writeSample(1234, 4321, 1'b0);
      checkVal("over_count", 64'(sampleCount), 64'(DEPTH));
      checkVal("over_nBus",  64'(nBus),        64'(DEPTH));

      // Full pass over DEPTH entries, last request wraps to entry 0
      startFeed("startFull");
      for (int i = 0; i < DEPTH; i++)
         requestNext($sformatf("full_adv%0d", i));
`ifdef SAMPLE_FEEDER_EPOCH_CNT_EN
      checkVal("epochFull", 64'(epochCnt), 64'd1);
`endif
      doneSignal = 1'b1;
      tick();
      doneSignal = 1'b0;
      checkVal("full_done_busy", 64'(busy), 64'd0);

      // clearMem beats same-cycle wrEn
      clearMem = 1'b1; wrEn = 1'b1; wrX1 = 16'd1; wrX2 = 16'd1; wrT = 1'b1;
      tick();
      clearMem = 1'b0; wrEn = 1'b0;
      checkVal("clr_count", 64'(sampleCount), 64'd0);
      checkVal("clr_full",  64'(full),        64'd0);
      checkVal("sb_drained", 64'(sbQ.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
